dec_pipe_stage: RTL and testbench

DEC_PIPE_STAGE -- requirements
Module: dec_pipe_stage

---
 rtl/dec_pkg.sv | 50 +++++
 rtl/regfile_p.sv | 49 ++++
 rtl/dec_pipe_stage.sv | 112 +++++++++++
 tb/tb_dec_pipe_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Decode-stage constants: opcode map, immediate-mode encodings and the
// opcode classification helpers shared by the decode pipeline stage.
package dec_pkg;

  localparam int unsigned OPW   = 6;
  localparam int unsigned IMMW  = 16;
  localparam int unsigned INSTW = 32;

  localparam logic [OPW-1:0] OP_BEQ  = 6'b000000;
  localparam logic [OPW-1:0] OP_BNE  = 6'b000001;
  localparam logic [OPW-1:0] OP_LW   = 6'b000011;
  localparam logic [OPW-1:0] OP_SW   = 6'b000111;
  localparam logic [OPW-1:0] OP_LB   = 6'b001111;
  localparam logic [OPW-1:0] OP_SB   = 6'b011111;
  localparam logic [OPW-1:0] OP_SLTI = 6'b110000;
  localparam logic [OPW-1:0] OP_ANDI = 6'b110010;
  localparam logic [OPW-1:0] OP_ORI  = 6'b110011;
  localparam logic [OPW-1:0] OP_ADDI = 6'b111000;
  localparam logic [OPW-1:0] OP_LUI  = 6'b111001;
  localparam logic [OPW-1:0] OP_JMP  = 6'b111111;

  typedef enum logic [1:0] {
    IMM_ZEXT     = 2'd0,
    IMM_SEXT     = 2'd1,
    IMM_SEXT_SH2 = 2'd2,
    IMM_HI16     = 2'd3
  } imm_mode_e;

  function automatic imm_mode_e imm_mode(input logic [OPW-1:0] op);
    imm_mode_e m;
    case (op)
      OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_LB, OP_SB: m = IMM_SEXT;
      OP_ANDI, OP_ORI:                              m = IMM_ZEXT;
      OP_JMP, OP_BEQ, OP_BNE:                       m = IMM_SEXT_SH2;
      OP_LUI:                                       m = IMM_HI16;
      default:                                      m = IMM_ZEXT;
    endcase
    return m;
  endfunction

  // Branches and stores compare/store the rd register, so port B reads rd.
  function automatic logic b_sel_rd(input logic [OPW-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_load_op(input logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/regfile_p.sv
// Two-read/one-write register file with r0 hardwired to zero and
// same-cycle write-through to both read ports.
module regfile_p #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DATAW-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [DATAW-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [DATAW-1:0] rd_data_b
);

  logic [DATAW-1:0] regs [NREGS];
  logic             wr_hit;

  assign wr_hit = !rst && wr_en && (wr_addr != '0) && (32'(wr_addr) < NREGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads of r0 or out-of-range addresses return zero.
  always_comb begin
    rd_data_a = '0;
    if ((rd_addr_a != '0) && (32'(rd_addr_a) < NREGS)) begin
      if (wr_hit && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
      else                                  rd_data_a = regs[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if ((rd_addr_b != '0) && (32'(rd_addr_b) < NREGS)) begin
      if (wr_hit && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
      else                                  rd_data_b = regs[rd_addr_b];
    end
  end

endmodule

// File: rtl/dec_pipe_stage.sv
// Decode pipeline stage: register read, immediate generation, load-use
// hazard detection and a valid/ready output register.
module dec_pipe_stage
  import dec_pkg::*;
#(
  parameter int unsigned DATAW = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  output logic             in_ready,
  input  logic             wb_wren,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DATAW-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] rf_a,
  output logic [DATAW-1:0] rf_b,
  output logic [DATAW-1:0] immed,
  output logic [AW-1:0]    rd,
  output logic [OPW-1:0]   opcode,
  output logic             is_load
);

  localparam int unsigned XW = (DATAW > 32) ? DATAW : 32;

  if ((AW < 1) || (AW > 5)) begin : g_bad_aw
    $error("dec_pipe_stage: NREGS gives an address width outside 1..5");
  end

  logic [OPW-1:0]   in_op;
  logic [AW-1:0]    in_rs;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rt;
  logic [AW-1:0]    in_b;
  logic [IMMW-1:0]  in_imm;
  logic [XW-1:0]    imm_sext;
  logic [XW-1:0]    imm_x;
  logic [DATAW-1:0] rd_a;
  logic [DATAW-1:0] rd_b;
  logic             hazard;
  logic             load_en;
  logic             accept;

  assign in_op  = instr[31:26];
  assign in_rs  = AW'(instr[25:21]);
  assign in_rd  = AW'(instr[20:16]);
  assign in_rt  = AW'(instr[15:11]);
  assign in_imm = instr[15:0];
  assign in_b   = b_sel_rd(in_op) ? in_rd : in_rt;

  // Immediate is built at max(DATAW, 32) and then truncated to DATAW.
  always_comb begin
    imm_sext = {{(XW-IMMW){in_imm[IMMW-1]}}, in_imm};
    imm_x    = XW'(in_imm);
    case (imm_mode(in_op))
      IMM_SEXT:     imm_x = imm_sext;
      IMM_SEXT_SH2: imm_x = imm_sext << 2;
      IMM_HI16:     imm_x = XW'({in_imm, 16'h0000});
      default:      imm_x = XW'(in_imm);
    endcase
  end

  // Only a valid load can stall; a bubble has out_valid low and never does.
  assign hazard   = out_valid && is_load && (rd != '0) &&
                    ((rd == in_rs) || (rd == in_b));
  assign load_en  = !out_valid || out_ready;
  assign in_ready = !rst && load_en && !hazard;
  assign accept   = in_valid && in_ready;

  regfile_p #(
    .DATAW (DATAW),
    .NREGS (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_wren),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (in_rs),
    .rd_data_a (rd_a),
    .rd_addr_b (in_b),
    .rd_data_b (rd_b)
  );

  // Output register: loads a new bundle or a bubble whenever it may advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rf_a      <= '0;
      rf_b      <= '0;
      immed     <= '0;
      rd        <= '0;
      opcode    <= '0;
      is_load   <= 1'b0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        rf_a    <= rd_a;
        rf_b    <= rd_b;
        immed   <= DATAW'(imm_x);
        rd      <= in_rd;
        opcode  <= in_op;
        is_load <= is_load_op(in_op);
      end
    end
  end

endmodule

// File: tb/tb_dec_pipe_stage.sv
// Self-checking bench for dec_pipe_stage: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_dec_pipe_stage;

  localparam int unsigned DATAW = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  localparam logic [5:0] T_BEQ = 6'b000000, T_LW = 6'b000011, T_SW = 6'b000111;
  localparam logic [5:0] T_ANDI = 6'b110010, T_ORI = 6'b110011, T_ADDI = 6'b111000;
  localparam logic [5:0] T_LUI = 6'b111001, T_ADD = 6'b100000;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, wb_wren, out_valid, out_ready, is_load;
  logic [31:0]      instr;
  logic [AW-1:0]    wb_addr, rd;
  logic [DATAW-1:0] wb_data, rf_a, rf_b, immed;
  logic [5:0]       opcode;

  dec_pipe_stage #(.DATAW(DATAW), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(in_ready),
    .wb_wren(wb_wren), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .rf_a(rf_a), .rf_b(rf_b), .immed(immed), .rd(rd), .opcode(opcode), .is_load(is_load)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid, m_load;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_rd;
  logic [5:0]  m_op;

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rdf, logic [15:0] imm);
    return {op, rs, rdf, imm};
  endfunction

  function automatic logic [31:0] ref_imm(logic [5:0] op, logic [15:0] imm);
    int s;
    s = int'($signed(imm));
    case (op)
      6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111: return 32'(s);
      6'b111111, 6'b000000, 6'b000001: return 32'(s * 4);
      6'b111001: return 32'(imm) * 32'd65536;
      default:   return 32'(imm);
    endcase
  endfunction

  function automatic logic [4:0] ref_baddr(logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'b000000 || op == 6'b000001 || op == 6'b000111 || op == 6'b011111) return ins[20:16];
    return ins[15:11];
  endfunction

  function automatic logic [31:0] ref_read(logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_wren && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic ref_ready();
    if (rst) return 1'b0;
    if (m_valid && m_load && m_rd != 5'd0 &&
        (m_rd == instr[25:21] || m_rd == ref_baddr(instr))) return 1'b0;
    return !m_valid || out_ready;
  endfunction

  // Advance the model over the coming edge, then wait for it.
  task automatic tick();
    logic acc;
    acc = in_valid && ref_ready();
    if (rst) begin
      m_valid = 0; m_load = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_op = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (!m_valid || out_ready) begin
        m_valid = acc;
        if (acc) begin
          m_a    = ref_read(instr[25:21]);
          m_b    = ref_read(ref_baddr(instr));
          m_imm  = ref_imm(instr[31:26], instr[15:0]);
          m_rd   = instr[20:16];
          m_op   = instr[31:26];
          m_load = (instr[31:26] == 6'b000011) || (instr[31:26] == 6'b001111);
        end
      end
      if (wb_wren && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; instr = mk(T_ADD, 5'd1, 5'd2, 16'h0); out_ready = 1;
    wb_wren = 1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if ({out_valid, rf_a, rf_b, immed, rd, opcode, is_load} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b a=%h b=%h imm=%h rd=%0d op=%b ld=%b want all 0",
                         out_valid, rf_a, rf_b, immed, rd, opcode, is_load);
    end
    rst = 0; wb_wren = 0;
    instr = mk(T_ADD, 5'd7, 5'd1, {5'd7, 11'd0});
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || rf_a !== 32'd0 || rf_b !== 32'd0) begin
      errors++; $display("FAIL reset_wb_discard: valid=%b a=%h b=%h want 1/0/0", out_valid, rf_a, rf_b);
    end
  endtask

  task automatic test_writethrough();
    in_valid = 1; out_ready = 1;
    instr = mk(T_ADDI, 5'd5, 5'd2, 16'h0001);
    wb_wren = 1; wb_addr = 5'd5; wb_data = 32'h12345678;
    #1; tick();
    checks++;
    if (rf_a !== 32'h12345678 || immed !== 32'd1 || rd !== 5'd2) begin
      errors++; $display("FAIL writethrough: a=%h imm=%h rd=%0d want 12345678/1/2", rf_a, immed, rd);
    end
    wb_wren = 0;
    instr = mk(T_ADD, 5'd5, 5'd6, {5'd5, 11'd0});
    #1; tick();
    checks++;
    if (rf_a !== 32'h12345678 || rf_b !== 32'h12345678) begin
      errors++; $display("FAIL reg_persist: a=%h b=%h want 12345678", rf_a, rf_b);
    end
  endtask

  task automatic test_imm_modes();
    logic [5:0]  ops [4];
    logic [31:0] exp [4];
    ops = '{T_ADDI, T_ANDI, T_BEQ, T_LUI};
    exp = '{32'hFFFF8004, 32'h00008004, 32'hFFFE0010, 32'h80040000};
    in_valid = 1; out_ready = 1; wb_wren = 0;
    for (int i = 0; i < 4; i++) begin
      instr = mk(ops[i], 5'd1, 5'd2, 16'h8004);
      #1; tick();
      checks++;
      if (immed !== exp[i] || opcode !== ops[i] || is_load !== 1'b0) begin
        errors++; $display("FAIL imm_mode_%0d: imm=%h op=%b ld=%b want %h/%b/0", i, immed, opcode, is_load, exp[i], ops[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [5:0] uses [2];
    logic [31:0] use_ins [2];
    uses = '{T_ADD, T_SW};
    use_ins = '{mk(T_ADD, 5'd3, 5'd4, {5'd2, 11'd0}), mk(T_SW, 5'd0, 5'd3, 16'h0008)};
    out_ready = 1; wb_wren = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 0; #1; tick();
      in_valid = 1; instr = mk(T_LW, 5'd1, 5'd3, 16'h0010);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu%0d_lw_ready: got %b want 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || is_load !== 1'b1 || rd !== 5'd3) begin
        errors++; $display("FAIL lu%0d_lw_out: valid=%b ld=%b rd=%0d want 1/1/3", k, out_valid, is_load, rd);
      end
      instr = use_ins[k];
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu%0d_stall: in_ready=%b want 0", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu%0d_bubble: out_valid=%b want 0", k, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu%0d_resume: in_ready=%b want 1", k, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || opcode !== uses[k]) begin
        errors++; $display("FAIL lu%0d_issue: valid=%b op=%b want 1/%b", k, out_valid, opcode, uses[k]);
      end
    end
    in_valid = 0; #1; tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1; in_valid = 1; wb_wren = 0;
    instr = mk(T_ADD, 5'd1, 5'd5, 16'h1000);
    #1; tick();
    out_ready = 0; instr = mk(T_ORI, 5'd2, 5'd6, 16'h00F0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || opcode !== T_ADD || rd !== 5'd5 || immed !== 32'h00001000) begin
        errors++; $display("FAIL bp_hold_%0d: valid=%b op=%b rd=%0d imm=%h want 1/%b/5/00001000",
                           i, out_valid, opcode, rd, immed, T_ADD);
      end
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      logic [5:0]  op;
      logic [31:0] want;
      op   = (i == 0) ? T_ORI : (i == 1) ? T_ADDI : T_ANDI;
      want = (i == 0) ? 32'h000000F0 : (i == 1) ? 32'hFFFFFFFF : 32'h0000FFFF;
      if (i > 0) instr = mk(op, 5'd3, 5'(7 + i), 16'hFFFF);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready_%0d: got %b want 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || opcode !== op || immed !== want) begin
        errors++; $display("FAIL bp_flow_%0d: valid=%b op=%b imm=%h want 1/%b/%h", i, out_valid, opcode, immed, op, want);
      end
    end
  endtask

  task automatic test_r0();
    out_ready = 1; in_valid = 0;
    wb_wren = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1; tick();
    in_valid = 1; instr = mk(T_ADD, 5'd0, 5'd1, {5'd0, 11'd0});
    #1; tick();
    checks++;
    if (out_valid !== 1'b1 || rf_a !== 32'd0 || rf_b !== 32'd0) begin
      errors++; $display("FAIL r0_read: valid=%b a=%h b=%h want 1/0/0", out_valid, rf_a, rf_b);
    end
    wb_wren = 0;
    instr = mk(T_LW, 5'd1, 5'd0, 16'h0004);
    #1; tick();
    instr = mk(T_ADD, 5'd0, 5'd2, {5'd0, 11'd0});
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_no_hazard: in_ready=%b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || opcode !== T_ADD) begin
      errors++; $display("FAIL r0_no_bubble: valid=%b op=%b want 1/%b", out_valid, opcode, T_ADD);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1; in_valid = 0;
    wb_wren = 1; wb_addr = 5'd5; wb_data = 32'hAAAA5555;
    #1; tick();
    wb_wren = 0; out_ready = 0; in_valid = 1;
    instr = mk(T_ADDI, 5'd5, 5'd9, 16'h1234);
    #1; tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || rf_a !== 32'hAAAA5555) begin
      errors++; $display("FAIL mr_stalled: valid=%b a=%h want 1/aaaa5555", out_valid, rf_a);
    end
    rst = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mr_in_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if ({out_valid, rf_a, rf_b, immed, rd, opcode, is_load} !== '0) begin
      errors++; $display("FAIL mr_outputs: valid=%b a=%h b=%h imm=%h rd=%0d op=%b ld=%b want all 0",
                         out_valid, rf_a, rf_b, immed, rd, opcode, is_load);
    end
    rst = 0; out_ready = 1;
    instr = mk(T_ADD, 5'd5, 5'd9, {5'd5, 11'd0});
    #1; tick();
    checks++;
    if (out_valid !== 1'b1 || rf_a !== 32'd0 || rf_b !== 32'd0) begin
      errors++; $display("FAIL mr_regs_clear: valid=%b a=%h b=%h want 1/0/0", out_valid, rf_a, rf_b);
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [14];
    logic [4:0] rt;
    logic [15:0] imm;
    pool = '{6'b000000, 6'b000001, 6'b000011, 6'b000011, 6'b000111, 6'b001111, 6'b011111,
             6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001, 6'b111111, 6'b100000};
    rst = 1; #1; tick(); rst = 0;
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rt        = 5'($urandom_range(0, 7));
      imm       = {rt, 11'($urandom)};
      instr     = mk(pool[$urandom_range(0, 13)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm);
      wb_wren   = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      checks++;
      if (in_ready !== ref_ready()) begin
        errors++; $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, ref_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid, m_valid);
      end else if (m_valid) begin
        checks++;
        if ({rf_a, rf_b, immed, rd, opcode, is_load} !== {m_a, m_b, m_imm, m_rd, m_op, m_load}) begin
          errors++; $display("FAIL rnd_bundle c=%0d: got a=%h b=%h imm=%h rd=%0d op=%b ld=%b want a=%h b=%h imm=%h rd=%0d op=%b ld=%b",
                             c, rf_a, rf_b, immed, rd, opcode, is_load, m_a, m_b, m_imm, m_rd, m_op, m_load);
        end
      end
    end
    rst = 0; in_valid = 0; wb_wren = 0; out_ready = 1;
    #1; tick();
  endtask

  initial begin
    rst = 1; in_valid = 0; instr = '0; out_ready = 1;
    wb_wren = 0; wb_addr = '0; wb_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_writethrough();
    test_imm_modes();
    test_load_use();
    test_backpressure();
    test_r0();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
